// File: rtl/msg_pkg.sv
// Shared definitions for the serial message path: FSM state encoding,
// message type, word geometry and a width helper for byte counters.
package msg_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2
  } msg_state_e;

  typedef enum logic {
    MSG_PARTICLE = 1'b0,
    MSG_MAP      = 1'b1
  } msg_type_e;

  // Number of bits needed to hold the unsigned value itself (not value-1).
  function automatic int min_bit_width(input int value);
    int width;
    width = 1;
    while ((value >> width) != 0) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/msg_byte_packer.sv
// Big-endian byte-to-word packer shared by both message types. Holds the
// shift word and the within-word byte index; the owner decides when a word
// is complete and when leftover bytes are flushed.
module msg_byte_packer
  import msg_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_i,
  input  logic                            clear_i,
  input  logic [7:0]                      byte_i,
  output logic [31:0]                     word_o,
  output logic [31:0]                     pad_word_o,
  output logic [$clog2(WORD_BYTES)-1:0]   idx_o,
  output logic                            last_o
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [31:0]      shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Next shift word / index: clear wins over load.
  always_comb begin
    // NOTE: every _d signal takes its held value first, so no branch can leave it unassigned and infer a latch.
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (load_i) begin
      shift_d = {shift_q[23:0], byte_i};
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  // Shift word and index registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  // Word completed by the byte currently presented (valid when last_o).
  assign word_o     = {shift_q[23:0], byte_i};
  // Held bytes moved to the top, low bytes zero-filled.
  assign pad_word_o = shift_q << (8 * (WORD_BYTES - int'(idx_q)));
  assign idx_o      = idx_q;
  assign last_o     = (idx_q == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/msg_word_loader.sv
// Turns the byte stream of a serial message receiver into 32-bit buffer
// writes, one write port per message type, with per-type write pointers.
module msg_word_loader
  import msg_pkg::*;
#(
  parameter int PARTICLE_MESSAGE_LENGHT = 8,
  parameter int MAP_MESSAGE_LENGHT      = 16,
  parameter int PARTICLE_ADDR_WIDTH     = 8,
  parameter int MAP_ADDR_WIDTH          = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     msg_in,
  input  logic                           particle_data_flag,
  input  logic                           map_data_flag,
  input  logic                           data_valid,
  input  logic                           ptr_clear,
  output logic                           particle_we,
  output logic [PARTICLE_ADDR_WIDTH-1:0] particle_addr,
  output logic [31:0]                    particle_wdata,
  output logic                           map_we,
  output logic [MAP_ADDR_WIDTH-1:0]      map_addr,
  output logic [31:0]                    map_wdata,
  output logic                           particle_msg_done,
  output logic                           map_msg_done,
  output logic                           msg_error
);

  localparam int MAX_LEN = (PARTICLE_MESSAGE_LENGHT > MAP_MESSAGE_LENGHT) ?
                           PARTICLE_MESSAGE_LENGHT : MAP_MESSAGE_LENGHT;
  localparam int CNT_W   = min_bit_width(MAX_LEN);
  localparam logic [CNT_W-1:0] P_LEN = CNT_W'(PARTICLE_MESSAGE_LENGHT);
  localparam logic [CNT_W-1:0] M_LEN = CNT_W'(MAP_MESSAGE_LENGHT);

  msg_state_e state_q, state_d;
  msg_type_e  type_q, type_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dv_q;

  logic [PARTICLE_ADDR_WIDTH-1:0] p_ptr_q, p_ptr_d, p_addr_q, p_addr_d;
  logic [MAP_ADDR_WIDTH-1:0]      m_ptr_q, m_ptr_d, m_addr_q, m_addr_d;
  logic [31:0] p_wdata_q, p_wdata_d, m_wdata_q, m_wdata_d;
  logic p_we_q, p_we_d, m_we_q, m_we_d;
  logic p_done_q, p_done_d, m_done_q, m_done_d, err_q, err_d;

  logic accept, type_flag, wr_en, pk_load, pk_clear, pk_last;
  logic [CNT_W-1:0] cur_len, start_len;
  logic [31:0] wr_word, pk_word, pk_pad;
  logic [$clog2(WORD_BYTES)-1:0] pk_idx;

  // One byte per rising edge of data_valid, however long it stays high.
  assign accept    = data_valid & ~dv_q;
  assign type_flag = (type_q == MSG_MAP) ? map_data_flag : particle_data_flag;
  assign cur_len   = (type_q == MSG_MAP) ? M_LEN : P_LEN;
  assign start_len = map_data_flag ? M_LEN : P_LEN;

  msg_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (pk_load),
    .clear_i    (pk_clear),
    .byte_i     (msg_in),
    .word_o     (pk_word),
    .pad_word_o (pk_pad),
    .idx_o      (pk_idx),
    .last_o     (pk_last)
  );

  // Message FSM next state plus registered-output next values.
  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    cnt_d     = cnt_q;
    p_ptr_d   = p_ptr_q;
    m_ptr_d   = m_ptr_q;
    p_addr_d  = p_addr_q;
    m_addr_d  = m_addr_q;
    p_wdata_d = p_wdata_q;
    m_wdata_d = m_wdata_q;
    p_we_d    = 1'b0;
    m_we_d    = 1'b0;
    p_done_d  = 1'b0;
    m_done_d  = 1'b0;
    err_d     = 1'b0;
    pk_load   = 1'b0;
    pk_clear  = 1'b0;
    wr_en     = 1'b0;
    wr_word   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (particle_data_flag ^ map_data_flag) begin
            type_d  = map_data_flag ? MSG_MAP : MSG_PARTICLE;
            cnt_d   = CNT_W'(1);
            pk_load = 1'b1;
            state_d = (start_len == CNT_W'(1)) ? ST_FLUSH : ST_COLLECT;
          end else begin
            err_d = 1'b1;  // ambiguous or missing type: drop the byte
          end
        end
      end
      ST_COLLECT: begin
        if (!type_flag) begin
          // Sender abandoned the message: forget the partial word.
          err_d    = 1'b1;
          pk_clear = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else if (accept) begin
          pk_load = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (pk_last) begin
            wr_en   = 1'b1;
            wr_word = pk_word;
          end
          if (cnt_d == cur_len) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (pk_idx != '0) begin
          wr_en   = 1'b1;
          wr_word = pk_pad;
        end
        if (type_q == MSG_MAP) m_done_d = 1'b1;
        else                   p_done_d = 1'b1;
        pk_clear = 1'b1;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A write always goes to the latched type only, so the strobes are exclusive.
    if (wr_en) begin
      if (type_q == MSG_MAP) begin
        m_we_d    = 1'b1;
        m_addr_d  = m_ptr_q;
        m_wdata_d = wr_word;
        m_ptr_d   = m_ptr_q + MAP_ADDR_WIDTH'(1);
      end else begin
        p_we_d    = 1'b1;
        p_addr_d  = p_ptr_q;
        p_wdata_d = wr_word;
        p_ptr_d   = p_ptr_q + PARTICLE_ADDR_WIDTH'(1);
      end
    end

    // Clear overrides the post-increment; a coincident write keeps its old address.
    if (ptr_clear) begin
      p_ptr_d = '0;
      m_ptr_d = '0;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      type_q    <= MSG_PARTICLE;
      cnt_q     <= '0;
      dv_q      <= 1'b0;
      p_ptr_q   <= '0;
      m_ptr_q   <= '0;
      p_addr_q  <= '0;
      m_addr_q  <= '0;
      p_wdata_q <= '0;
      m_wdata_q <= '0;
      p_we_q    <= 1'b0;
      m_we_q    <= 1'b0;
      p_done_q  <= 1'b0;
      m_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      cnt_q     <= cnt_d;
      dv_q      <= data_valid;
      p_ptr_q   <= p_ptr_d;
      m_ptr_q   <= m_ptr_d;
      p_addr_q  <= p_addr_d;
      m_addr_q  <= m_addr_d;
      p_wdata_q <= p_wdata_d;
      m_wdata_q <= m_wdata_d;
      p_we_q    <= p_we_d;
      m_we_q    <= m_we_d;
      p_done_q  <= p_done_d;
      m_done_q  <= m_done_d;
      err_q     <= err_d;
    end
  end

  assign particle_we       = p_we_q;
  assign particle_addr     = p_addr_q;
  assign particle_wdata    = p_wdata_q;
  assign map_we            = m_we_q;
  assign map_addr          = m_addr_q;
  assign map_wdata         = m_wdata_q;
  assign particle_msg_done = p_done_q;
  assign map_msg_done      = m_done_q;
  assign msg_error         = err_q;

endmodule

// File: tb/tb_msg_word_loader.sv
// Directed bench for msg_word_loader: a default instance (a) and one with
// 6-byte map messages (b) share all inputs; a negedge monitor logs writes
// and pulses, and the main sequence compares the logs against hand values.
module tb_msg_word_loader;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic       clk, reset, particle_data_flag, map_data_flag, data_valid, ptr_clear;
  logic [7:0] msg_in;

  logic        a_pwe, a_mwe, a_pdone, a_mdone, a_err;
  logic [7:0]  a_paddr;
  logic [9:0]  a_maddr;
  logic [31:0] a_pwdata, a_mwdata;
  logic        b_pwe, b_mwe, b_pdone, b_mdone, b_err;
  logic [7:0]  b_paddr;
  logic [9:0]  b_maddr;
  logic [31:0] b_pwdata, b_mwdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  wr_t a_pq[$], a_mq[$], b_mq[$];
  int  a_pdone_cnt, a_mdone_cnt, a_err_cnt, b_mdone_cnt, b_err_cnt, both_cnt;
  int  a_pdone_cyc, b_mdone_cyc;

  msg_word_loader dut_a (
    .clk(clk), .reset(reset), .msg_in(msg_in),
    .particle_data_flag(particle_data_flag), .map_data_flag(map_data_flag),
    .data_valid(data_valid), .ptr_clear(ptr_clear),
    .particle_we(a_pwe), .particle_addr(a_paddr), .particle_wdata(a_pwdata),
    .map_we(a_mwe), .map_addr(a_maddr), .map_wdata(a_mwdata),
    .particle_msg_done(a_pdone), .map_msg_done(a_mdone), .msg_error(a_err)
  );

  msg_word_loader #(.MAP_MESSAGE_LENGHT(6)) dut_b (
    .clk(clk), .reset(reset), .msg_in(msg_in),
    .particle_data_flag(particle_data_flag), .map_data_flag(map_data_flag),
    .data_valid(data_valid), .ptr_clear(ptr_clear),
    .particle_we(b_pwe), .particle_addr(b_paddr), .particle_wdata(b_pwdata),
    .map_we(b_mwe), .map_addr(b_maddr), .map_wdata(b_mwdata),
    .particle_msg_done(b_pdone), .map_msg_done(b_mdone), .msg_error(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every strobe and pulse, away from the active edge.
  always @(negedge clk) begin
    wr_t e;
    e.cyc = cyc;
    if (a_pwe) begin e.addr = 16'(a_paddr); e.data = a_pwdata; a_pq.push_back(e); end
    if (a_mwe) begin e.addr = 16'(a_maddr); e.data = a_mwdata; a_mq.push_back(e); end
    if (b_mwe) begin e.addr = 16'(b_maddr); e.data = b_mwdata; b_mq.push_back(e); end
    if (a_pdone) begin a_pdone_cnt++; a_pdone_cyc = cyc; end
    if (a_mdone) a_mdone_cnt++;
    if (b_mdone) begin b_mdone_cnt++; b_mdone_cyc = cyc; end
    if (a_err) a_err_cnt++;
    if (b_err) b_err_cnt++;
    if ((a_pwe && a_mwe) || (b_pwe && b_mwe)) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    a_pq.delete(); a_mq.delete(); b_mq.delete();
    a_pdone_cnt = 0; a_mdone_cnt = 0; a_err_cnt = 0;
    b_mdone_cnt = 0; b_err_cnt = 0;
    a_pdone_cyc = -1; b_mdone_cyc = -1;
  endtask

  // One byte: data_valid high for 'hold' cycles, then low for one cycle.
  // ptr_clear (if set) coincides with the accepting edge.
  task automatic send(input logic [7:0] b, input int hold, input logic clr);
    msg_in = b; data_valid = 1'b1; ptr_clear = clr;
    tick(1);
    ptr_clear = 1'b0;
    if (hold > 1) tick(hold - 1);
    data_valid = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1; msg_in = '0; particle_data_flag = 1'b0; map_data_flag = 1'b0;
    data_valid = 1'b0; ptr_clear = 1'b0; both_cnt = 0;
    clear_logs();
    tick(3);

    // Reset state.
    check("rst_p_we",    32'(a_pwe),    32'd0);
    check("rst_p_addr",  32'(a_paddr),  32'd0);
    check("rst_p_wdata", a_pwdata,      32'd0);
    check("rst_m_we",    32'(a_mwe),    32'd0);
    check("rst_done",    32'({a_pdone, a_mdone}), 32'd0);
    check("rst_err",     32'(a_err),    32'd0);
    reset = 1'b0;
    tick(2);

    // Default particle message, data_valid held 3 cycles per byte.
    clear_logs();
    particle_data_flag = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i), 3, 1'b0);
    tick(4);
    particle_data_flag = 1'b0;
    tick(2);
    check("p8_nwr",    32'(a_pq.size()), 32'd2);
    check("p8_addr0",  32'(a_pq[0].addr), 32'd0);
    check("p8_data0",  a_pq[0].data, 32'h01020304);
    check("p8_addr1",  32'(a_pq[1].addr), 32'd1);
    check("p8_data1",  a_pq[1].data, 32'h05060708);
    check("p8_done",   32'(a_pdone_cnt), 32'd1);
    check("p8_done_t", 32'(a_pdone_cyc), 32'(a_pq[1].cyc + 1));
    check("p8_err",    32'(a_err_cnt), 32'd0);

    // Reset after 3 bytes of a particle message (pointer was 2).
    clear_logs();
    particle_data_flag = 1'b1;
    send(8'h11, 1, 1'b0); send(8'h22, 1, 1'b0); send(8'h33, 1, 1'b0);
    reset = 1'b1;
    tick(1);
    check("mid_rst_outs", 32'({a_pwe, a_mwe, a_pdone, a_mdone, a_err}), 32'd0);
    check("mid_rst_addr", 32'(a_paddr), 32'd0);
    reset = 1'b0;
    tick(1);
    check("mid_rst_nwr",  32'(a_pq.size()), 32'd0);
    check("mid_rst_pls",  32'(a_pdone_cnt + a_err_cnt), 32'd0);
    for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i), 1, 1'b0);
    tick(4);
    particle_data_flag = 1'b0;
    tick(2);
    check("post_rst_nwr",   32'(a_pq.size()), 32'd2);
    check("post_rst_addr0", 32'(a_pq[0].addr), 32'd0);
    check("post_rst_data0", a_pq[0].data, 32'hC0C1C2C3);
    check("post_rst_data1", a_pq[1].data, 32'hC4C5C6C7);
    check("post_rst_err",   32'(a_err_cnt), 32'd0);

    // Both flags high, then both low: byte dropped with an error each.
    clear_logs();
    particle_data_flag = 1'b1; map_data_flag = 1'b1;
    send(8'h55, 1, 1'b0);
    particle_data_flag = 1'b0; map_data_flag = 1'b0;
    send(8'h66, 1, 1'b0);
    tick(2);
    check("flags_err", 32'(a_err_cnt), 32'd2);
    check("flags_nwr", 32'(a_pq.size() + a_mq.size()), 32'd0);
    check("flags_done", 32'(a_pdone_cnt + a_mdone_cnt), 32'd0);

    // 6-byte map message on instance b: last word zero-padded.
    clear_logs();
    map_data_flag = 1'b1;
    for (int i = 0; i < 6; i++) send(8'hAA + 8'(i), 2, 1'b0);
    tick(4);
    map_data_flag = 1'b0;
    tick(2);
    check("m6_nwr",    32'(b_mq.size()), 32'd2);
    check("m6_addr0",  32'(b_mq[0].addr), 32'd0);
    check("m6_data0",  b_mq[0].data, 32'hAAABACAD);
    check("m6_addr1",  32'(b_mq[1].addr), 32'd1);
    check("m6_data1",  b_mq[1].data, 32'hAEAF0000);
    check("m6_done",   32'(b_mdone_cnt), 32'd1);
    check("m6_done_t", 32'(b_mdone_cyc), 32'(b_mq[1].cyc));
    check("m6_err",    32'(b_err_cnt), 32'd0);

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Map flag drops after 5 of 16 bytes, then a full map message.
    clear_logs();
    map_data_flag = 1'b1;
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1, 1'b0);
    tick(1);
    map_data_flag = 1'b0;
    tick(3);
    check("abort_nwr",  32'(a_mq.size()), 32'd1);
    check("abort_data", a_mq[0].data, 32'h10111213);
    check("abort_err",  32'(a_err_cnt), 32'd1);
    check("abort_done", 32'(a_mdone_cnt), 32'd0);
    map_data_flag = 1'b1;
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1, 1'b0);
    tick(4);
    map_data_flag = 1'b0;
    tick(2);
    check("m16_nwr",   32'(a_mq.size()), 32'd5);
    check("m16_addr1", 32'(a_mq[1].addr), 32'd1);
    check("m16_data1", a_mq[1].data, 32'h20212223);
    check("m16_addr4", 32'(a_mq[4].addr), 32'd4);
    check("m16_data4", a_mq[4].data, 32'h2C2D2E2F);
    check("m16_done",  32'(a_mdone_cnt), 32'd1);

    // ptr_clear coincident with the first word's write (pointer was 2).
    particle_data_flag = 1'b1;
    for (int i = 0; i < 8; i++) send(8'hD0 + 8'(i), 1, 1'b0);
    tick(3);
    clear_logs();
    for (int i = 0; i < 8; i++) send(8'hE0 + 8'(i), 1, (i == 3));
    tick(3);
    particle_data_flag = 1'b0;
    check("clr_addr0", 32'(a_pq[0].addr), 32'd2);
    check("clr_data0", a_pq[0].data, 32'hE0E1E2E3);
    check("clr_addr1", 32'(a_pq[1].addr), 32'd0);
    clear_logs();
    map_data_flag = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), 1, 1'b0);
    tick(3);
    map_data_flag = 1'b0;
    check("clr_map_addr0", 32'(a_mq[0].addr), 32'd0);

    // Particle pointer is 1: 127 messages bring it to 255, then wrap.
    particle_data_flag = 1'b1;
    for (int m = 0; m < 127; m++) begin
      for (int i = 0; i < 8; i++) send(8'(m + i), 1, 1'b0);
      tick(2);
    end
    clear_logs();
    for (int i = 0; i < 8; i++) send(8'hF0 + 8'(i), 1, 1'b0);
    tick(4);
    particle_data_flag = 1'b0;
    tick(2);
    check("wrap_nwr",   32'(a_pq.size()), 32'd2);
    check("wrap_addr0", 32'(a_pq[0].addr), 32'd255);
    check("wrap_data0", a_pq[0].data, 32'hF0F1F2F3);
    check("wrap_addr1", 32'(a_pq[1].addr), 32'd0);
    check("wrap_data1", a_pq[1].data, 32'hF4F5F6F7);
    check("wrap_err",   32'(a_err_cnt), 32'd0);
    check("wrap_done",  32'(a_pdone_cnt), 32'd1);

    check("we_exclusive", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
